// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package dff_reg_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Never returns 0, so the result can always size a vector.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the arbiter: request/data in, grant and register state out.
interface dff_reg_arbiter_if
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);

  localparam int OW = clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic [OW-1:0]          owner;

  modport master (output req, wdata, input gnt, q, busy, owner);
  modport slave  (input req, wdata, output gnt, q, busy, owner);

endinterface

// File: rtl/dff_reg_load.sv
// WIDTH-bit flip-flop register with load enable and asynchronous active-high reset.
module dff_reg_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that is the sole writer of a shared register; each grant
// allows up to MAX_BURST loads and is followed by one idle turnaround cycle.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  dff_reg_arbiter_if.slave bus
);

  localparam int OW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;

  logic             w_found;
  logic [OW-1:0]    w_pick;
  logic [OW-1:0]    w_idx;
  logic             w_ownerReq;
  logic             w_load;
  logic [WIDTH-1:0] w_ldata;
  logic [WIDTH-1:0] w_q;

  // Priority search starting at the rotation pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = OW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_ownerReq = 1'b0;
    w_ldata    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_ownerReq = bus.req[i];
        w_ldata    = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_load = (r_state == GRANT) && w_ownerReq;

  // Release happens on a dropped request or after the final burst load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt   <= ONE_HOT0 << w_pick;
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_ownerReq) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (!w_ownerReq || (r_cnt == LAST_CNT)) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  dff_reg_load #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_d   (w_ldata),
    .o_q   (w_q)
  );

  assign bus.gnt   = r_gnt;
  assign bus.q     = w_q;
  assign bus.busy  = r_busy;
  assign bus.owner = r_owner;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter: a behavioural model predicts each edge,
// expectations are queued on drive and compared one edge later.
module tb_dff_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] q;
    logic       busy;
    logic [1:0] owner;
  } exp_t;

  logic clk;
  logic rst;

  exp_t        sbQueue[$];
  int          grantLog[$];
  int          errorCount;
  int          checkCount;
  logic [31:0] wdataV;
  bit          prevBusy;

  int         mBusy;
  int         mOwner;
  int         mPtr;
  int         mCnt;
  logic [3:0] mGnt;
  logic [7:0] mQ;

  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dff_reg_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mBusy    = 0;
    mOwner   = 0;
    mPtr     = 0;
    mCnt     = 0;
    mGnt     = '0;
    mQ       = '0;
    prevBusy = 1'b0;
  endtask

  // Behavioural next-state prediction for one rising edge.
  task automatic modelStep(input logic [3:0] reqV, input logic [31:0] wd);
    int  idx;
    bit  rel;
    rel = 1'b0;
    if (mBusy == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if (reqV[idx]) begin
          mGnt   = 4'(1 << idx);
          mOwner = idx;
          mCnt   = 0;
          mBusy  = 1;
          break;
        end
      end
    end else begin
      if (reqV[mOwner]) begin
        mQ = wd[mOwner*8 +: 8];
        mCnt++;
        if (mCnt == MB) rel = 1'b1;
      end else begin
        rel = 1'b1;
      end
      if (rel) begin
        mGnt  = '0;
        mBusy = 0;
        mPtr  = (mOwner + 1) % N;
      end
    end
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    e = sbQueue.pop_front();
    checkOutput({tag, ".gnt"},   32'(bus.gnt),   32'(e.gnt));
    checkOutput({tag, ".q"},     32'(bus.q),     32'(e.q));
    checkOutput({tag, ".busy"},  32'(bus.busy),  32'(e.busy));
    checkOutput({tag, ".owner"}, 32'(bus.owner), 32'(e.owner));
    if (bus.busy && !prevBusy) grantLog.push_back(int'(bus.owner));
    prevBusy = bus.busy;
  endtask

  // Drive between edges, queue the prediction, then compare just after the edge.
  task automatic applyStimulus(input logic [3:0] reqV, input string tag);
    exp_t e;
    bus.req   = reqV;
    bus.wdata = wdataV;
    modelStep(reqV, wdataV);
    e.gnt   = mGnt;
    e.q     = mQ;
    e.busy  = 1'(mBusy);
    e.owner = 2'(mOwner);
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    popCompare(tag);
  endtask

  task automatic doReset();
    bus.req = '0;
    rst     = 1'b1;
    #3;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, ".gnt"},   32'(bus.gnt),   32'h0);
    checkOutput({tag, ".q"},     32'(bus.q),     32'h0);
    checkOutput({tag, ".busy"},  32'(bus.busy),  32'h0);
    checkOutput({tag, ".owner"}, 32'(bus.owner), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int exp3[5];
    exp3 = '{0, 1, 2, 3, 0};
    errorCount = 0;
    checkCount = 0;
    wdataV     = '0;
    modelReset();

    // Reset held with all requests active: outputs stay cleared.
    rst       = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = '0;
    #3;
    checkIdleReset("s1.async");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkIdleReset("s1.held");
    end
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b1111, "s1.edge1");
    checkOutput("s1.firstGnt", 32'(bus.gnt), 32'h1);

    // Single requester load, then release and hold.
    doReset();
    wdataV = {8'h00, 8'h00, 8'hA5, 8'h00};
    applyStimulus(4'b0010, "s2.grant");
    checkOutput("s2.owner", 32'(bus.owner), 32'd1);
    applyStimulus(4'b0010, "s2.load");
    checkOutput("s2.qLoad", 32'(bus.q), 32'hA5);
    applyStimulus(4'b0000, "s2.drop");
    checkOutput("s2.gntDrop", 32'(bus.gnt), 32'h0);
    repeat (3) applyStimulus(4'b0000, "s2.hold");
    checkOutput("s2.qHold", 32'(bus.q), 32'hA5);

    // Full contention: round-robin order with bursts and turnaround gaps.
    doReset();
    wdataV = {8'h13, 8'h12, 8'h11, 8'h10};
    grantLog.delete();
    repeat (25) applyStimulus(4'b1111, "s3.rr");
    checkOutput("s3.grantCount", 32'(grantLog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grantLog.size()) checkOutput($sformatf("s3.order%0d", i), 32'(grantLog[i]), 32'(exp3[i]));
    end

    // Early drop, skip of idle requesters, then wrap back to 0.
    doReset();
    wdataV = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    applyStimulus(4'b0001, "s4.grant0");
    applyStimulus(4'b0001, "s4.load1");
    applyStimulus(4'b0001, "s4.load2");
    applyStimulus(4'b1000, "s4.drop");
    checkOutput("s4.qAfterDrop", 32'(bus.q), 32'hC0);
    checkOutput("s4.busyAfterDrop", 32'(bus.busy), 32'h0);
    applyStimulus(4'b1001, "s4.grant3");
    checkOutput("s4.skipOwner", 32'(bus.owner), 32'd3);
    repeat (4) applyStimulus(4'b1001, "s5.burst3");
    checkOutput("s5.qOwner3", 32'(bus.q), 32'hC3);
    applyStimulus(4'b1001, "s5.wrap");
    checkOutput("s5.wrapOwner", 32'(bus.owner), 32'd0);
    checkOutput("s5.wrapGnt", 32'(bus.gnt), 32'h1);

    // Reset between edges mid-burst aborts it without a load.
    applyStimulus(4'b0001, "s6.load1");
    applyStimulus(4'b0001, "s6.load2");
    checkOutput("s6.qBefore", 32'(bus.q), 32'hC0);
    rst = 1'b1;
    #1;
    checkIdleReset("s6.abort");
    @(posedge clk);
    #1;
    checkIdleReset("s6.held");
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0100, "s6.regrant");
    checkOutput("s6.owner2", 32'(bus.owner), 32'd2);

    checkOutput("sb.drained", 32'(sbQueue.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
